// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a RAM: 10-bit command frames in on mosi,
// read data out on miso, one rx_valid strobe per completed frame.
module spi_slave_ctrl #(
  parameter int RD_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  localparam int WW = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_ss_hi;
  logic [3:0]    r_cnt;
  logic [9:0]    r_frame;
  logic          r_done;
  logic [9:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rd_addr_seen;
  logic          r_wait_en;
  logic [WW-1:0] r_wait_cnt;
  logic          r_shift_en;
  logic [3:0]    r_sh_cnt;
  logic [7:0]    r_tx_sr;
  logic          r_miso;
  logic          w_in_frame;

  assign miso     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  assign w_in_frame = (r_state == WRITE) ||
                      (r_state == READ_ADD) ||
                      (r_state == READ_DATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // A frame only starts after ss_n has been seen high since reset
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (!ss_n && r_ss_hi) w_next = CHK_CMD;
      CHK_CMD:
        if (!mosi)               w_next = WRITE;
        else if (r_rd_addr_seen) w_next = READ_DATA;
        else                     w_next = READ_ADD;
      default:
        w_next = r_state;
    endcase
    if (ss_n) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ss_hi        <= 1'b0;
      r_cnt          <= '0;
      r_frame        <= '0;
      r_done         <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_wait_en      <= 1'b0;
      r_wait_cnt     <= '0;
      r_shift_en     <= 1'b0;
      r_sh_cnt       <= '0;
      r_tx_sr        <= '0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= r_done;
      r_done     <= 1'b0;
      if (ss_n) r_ss_hi <= 1'b1;
      // Completion survives ss_n rising right after the last bit
      if (r_done) begin
        r_rx_data <= r_frame;
        if (r_state == READ_ADD)
          r_rd_addr_seen <= 1'b1;
        else if (r_state == READ_DATA)
          r_rd_addr_seen <= 1'b0;
      end
      if (ss_n) begin
        r_cnt      <= '0;
        r_frame    <= '0;
        r_wait_en  <= 1'b0;
        r_wait_cnt <= '0;
        r_shift_en <= 1'b0;
        r_sh_cnt   <= '0;
        r_tx_sr    <= '0;
        r_miso     <= 1'b0;
      end else begin
        if (r_state == CHK_CMD) begin
          r_frame <= {mosi, 9'd0};
          r_cnt   <= '0;
        end
        if (w_in_frame && r_cnt != 4'd9) begin
          r_frame <= {r_frame[9], r_frame[7:0], mosi};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd8) r_done <= 1'b1;
        end
        // tx_valid becomes eligible only after the rx_valid cycle
        if (r_state == READ_DATA && r_rx_valid) begin
          r_wait_en  <= 1'b1;
          r_wait_cnt <= '0;
        end
        if (r_wait_en) begin
          if (tx_valid) begin
            r_tx_sr    <= tx_data;
            r_wait_en  <= 1'b0;
            r_shift_en <= 1'b1;
            r_sh_cnt   <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_wait_en <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        if (r_shift_en) begin
          if (r_sh_cnt == 4'd8) begin
            r_miso     <= 1'b0;
            r_shift_en <= 1'b0;
          end else begin
            r_miso   <= r_tx_sr[7];
            r_tx_sr  <= {r_tx_sr[6:0], 1'b0};
            r_sh_cnt <= r_sh_cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: frame table against a small RAM
// model, then abort, late-ss_n, timeout and async-reset sequences.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] mem [256];
  logic [7:0] waddr;
  logic [7:0] raddr;
  logic       ram_tv;
  logic       ram_en;
  logic       late_tv;

  spi_slave_ctrl #(.RD_WAIT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_valid = ram_en ? ram_tv : late_tv;

  // RAM: read data appears the cycle after the read command strobe
  // and tx_valid is left high afterwards.
  initial begin
    waddr   = 8'h00;
    raddr   = 8'h00;
    ram_tv  = 1'b0;
    tx_data = 8'h00;
  end

  always @(posedge clk) begin
    if (rx_valid) begin
      case (rx_data[9:8])
        2'b00: waddr <= rx_data[7:0];
        2'b01: mem[waddr] <= rx_data[7:0];
        2'b10: raddr <= rx_data[7:0];
        default: begin
          tx_data <= mem[raddr];
          ram_tv  <= 1'b1;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic shift_bits(input logic [9:0] f);
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      mosi = f[i];
      tick();
    end
    mosi = 1'b0;
  endtask

  task automatic run_frame(input logic [9:0] f, input logic [9:0] exp_rx,
                           input logic exp_seen, input logic [11:0] exp_m,
                           input int hold);
    logic [11:0] m;
    logic        quiet;
    int          vcnt;
    quiet = 1'b0;
    vcnt  = 0;
    m     = '0;
    shift_bits(f);
    chk($sformatf("early_valid_%h", f), rx_valid, 0);
    tick();
    chk($sformatf("rx_valid_%h", f), rx_valid, 1);
    chk($sformatf("rx_data_%h", f), rx_data, exp_rx);
    for (int k = 0; k < 12; k++) begin
      tick();
      m[11-k] = miso;
      vcnt += int'(rx_valid);
    end
    chk($sformatf("pulse_len_%h", f), vcnt, 0);
    chk($sformatf("rd_seen_%h", f), dut.r_rd_addr_seen, exp_seen);
    chk($sformatf("miso_seq_%h", f), m, exp_m);
    for (int k = 0; k < hold; k++) begin
      if (k == 20) late_tv = 1'b1;
      tick();
      quiet |= miso;
    end
    chk($sformatf("miso_quiet_%h", f), quiet, 0);
    ss_n = 1'b1;
    tick();
    tick();
  endtask

  typedef struct {
    logic [9:0]  f;
    logic [9:0]  exp_rx;
    logic        exp_seen;
    logic [11:0] exp_m;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int vcnt;
    tbl[0] = '{10'h02A, 10'h02A, 1'b0, 12'h000};
    tbl[1] = '{10'h1C3, 10'h1C3, 1'b0, 12'h000};
    tbl[2] = '{10'h22A, 10'h22A, 1'b1, 12'h000};
    tbl[3] = '{10'h300, 10'h300, 1'b0, 12'h30C};
    tbl[4] = '{10'h0F0, 10'h0F0, 1'b0, 12'h000};
    tbl[5] = '{10'h15A, 10'h15A, 1'b0, 12'h000};
    tbl[6] = '{10'h2F0, 10'h2F0, 1'b1, 12'h000};
    tbl[7] = '{10'h3FF, 10'h3FF, 1'b0, 12'h168};
    tbl[8] = '{10'h22A, 10'h22A, 1'b1, 12'h000};
    tbl[9] = '{10'h3AA, 10'h3AA, 1'b0, 12'h30C};

    rst     = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    ram_en  = 1'b1;
    late_tv = 1'b0;
    tick();
    tick();
    chk("rst_miso", miso, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rd_seen", dut.r_rd_addr_seen, 0);
    #2 rst = 1'b1;
    tick();

    foreach (tbl[i])
      run_frame(tbl[i].f, tbl[i].exp_rx, tbl[i].exp_seen, tbl[i].exp_m, 0);

    // abort after five bits of a write frame
    ss_n = 1'b0;
    tick();
    for (int i = 9; i >= 5; i--) begin
      mosi = tbl[0].f[i] | 1'b1;
      if (i == 9) mosi = 1'b0;
      tick();
    end
    ss_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      vcnt += int'(rx_valid);
    end
    chk("abort_no_valid", vcnt, 0);
    chk("abort_hold_rx", rx_data, 10'h3AA);
    run_frame(10'h055, 10'h055, 1'b0, 12'h000, 0);

    // ss_n rises right after bit 0 is captured
    shift_bits(10'h1A5);
    ss_n = 1'b1;
    tick();
    chk("late_ss_valid", rx_valid, 1);
    chk("late_ss_data", rx_data, 10'h1A5);
    tick();
    chk("late_ss_pulse", rx_valid, 0);
    run_frame(10'h0F0, 10'h0F0, 1'b0, 12'h000, 0);

    // read data never arrives in time; a late tx_valid is ignored
    ram_en = 1'b0;
    run_frame(10'h211, 10'h211, 1'b1, 12'h000, 0);
    run_frame(10'h300, 10'h300, 1'b0, 12'h000, 32);
    late_tv = 1'b0;
    ram_en  = 1'b1;

    // async reset while rx_valid and rd_addr_seen are high
    shift_bits(10'h22A);
    tick();
    chk("pre_rst_valid", rx_valid, 1);
    chk("pre_rst_seen", dut.r_rd_addr_seen, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", rx_valid, 0);
    chk("arst_seen", dut.r_rd_addr_seen, 0);
    chk("arst_rx_data", rx_data, 0);
    #1 rst = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 14; k++) begin
      mosi = k[0];
      tick();
      vcnt += int'(rx_valid);
    end
    chk("restart_needs_ss", vcnt, 0);
    ss_n = 1'b1;
    tick();

    // async reset in the middle of shift-out
    run_frame(10'h22A, 10'h22A, 1'b1, 12'h000, 0);
    shift_bits(10'h300);
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_miso", miso, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_miso", miso, 0);
    #1 rst = 1'b1;
    ss_n = 1'b1;
    tick();
    run_frame(10'h02A, 10'h02A, 1'b0, 12'h000, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
